// File: rtl/btn_input_conditioner_if.sv
// Pushbutton conditioner bus: raw levels and read strobe in, conditioned value and change pulse out.
interface btn_input_conditioner_if;
    logic [3:0] btn_raw;
    logic       rd_strobe;
    logic [3:0] btn_out;
    logic       btn_change;

    modport master (
        output btn_raw,
        output rd_strobe,
        input  btn_out,
        input  btn_change
    );

    modport slave (
        input  btn_raw,
        input  rd_strobe,
        output btn_out,
        output btn_change
    );
endinterface

// File: rtl/btn_input_conditioner.sv
// Synchronizes and debounces four pushbuttons for the core's IN port.
// Define BTN_EDGE_LATCH_EN to present sticky press latches (cleared by rd_strobe) instead of levels.
module btn_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    btn_input_conditioner_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         sync1_reg;
    logic [3:0]         sync2_reg;
    logic [3:0]         stable_reg;
    logic [3:0]         stable_next;
    logic [3:0][CW-1:0] count_reg;
    logic [3:0][CW-1:0] count_next;
    logic               btn_change_reg;

    // A counter only advances while the synchronized level disagrees with the
    // accepted one; any agreement restarts it, so bounces never accumulate.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            logic mismatch;
            logic at_max;

            assign mismatch = sync2_reg[gi] ^ stable_reg[gi];
            assign at_max   = (count_reg[gi] == COUNT_MAX);

            assign count_next[gi]  = (mismatch && !at_max) ? count_reg[gi] + CW'(1) : '0;
            assign stable_next[gi] = (mismatch && at_max) ? sync2_reg[gi] : stable_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg      <= '0;
            sync2_reg      <= '0;
            stable_reg     <= '0;
            count_reg      <= '0;
            btn_change_reg <= 1'b0;
        end else begin
            sync1_reg      <= bus.btn_raw;
            sync2_reg      <= sync1_reg;
            stable_reg     <= stable_next;
            count_reg      <= count_next;
            btn_change_reg <= |(stable_next ^ stable_reg);
        end
    end

    assign bus.btn_change = btn_change_reg;

`ifdef BTN_EDGE_LATCH_EN
    logic [3:0] press_reg;
    logic [3:0] press_next;

    // A fresh press outranks a same-edge read clear so it is never lost.
    assign press_next = (press_reg & ~{4{bus.rd_strobe}}) | (stable_next & ~stable_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_reg <= '0;
        end else begin
            press_reg <= press_next;
        end
    end

    assign bus.btn_out = press_reg;
`else
    logic rd_strobe_unused;

    assign rd_strobe_unused = bus.rd_strobe;
    assign bus.btn_out      = stable_reg;
`endif

endmodule
